// File: rtl/ped_crossing_controller.sv
// Purpose : pedestrian crosswalk controller; debounces the pushbutton, raises a
//           held crossing request, and runs the walk / flashing don't-walk sequence
//           once the traffic light shows red.
// Ports   : clk, reset (sync, active-high), button_raw (raw pushbutton),
//           lights {red,yellow,green}; outputs request (level), walk, dont_walk,
//           count (cycles left in WALK/FLASH), done (end-of-crossing pulse),
//           error (pulse when lights leave red during WALK/FLASH).
// Timing  : all outputs are registered; press to request takes DEBOUNCE_CYCLES
//           edges, red to walk takes one edge.
module ped_crossing_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int WALK_CYCLES     = 8,
   parameter int FLASH_CYCLES    = 6,
   parameter int FLASH_PERIOD    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button_raw,
   input  logic [2:0] lights,
   output logic       request,
   output logic       walk,
   output logic       dont_walk,
   output logic [3:0] count,
   output logic       done,
   output logic       error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQUEST,
      S_WALK,
      S_FLASH
   } state_t;

   localparam logic [3:0] DEB_MAX    = 4'(DEBOUNCE_CYCLES);
   localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYCLES - 1);
   localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES - 1);
   localparam logic [2:0] PER_LAST   = 3'(FLASH_PERIOD - 1);
   localparam logic [2:0] RED        = 3'b100;

   state_t     state_q, state_d;
   logic [3:0] deb_cnt_q, deb_cnt_d;
   logic       armed_q, armed_d;
   logic       pending_q, pending_d;
   logic [2:0] timer_q, timer_d;
   logic       request_q, request_d;
   logic       walk_q, walk_d;
   logic       dw_q, dw_d;
   logic [3:0] count_q, count_d;
   logic       done_q, done_d;
   logic       error_q, error_d;

   logic press_ev;
   logic red;
   logic pend_eff;

   assign red = (lights == RED);

   // Debouncer: counter saturates while held; 'armed' guarantees one event per
   // press and is only re-armed by a low sample.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      armed_d   = armed_q;
      press_ev  = 1'b0;
      if (!button_raw) begin
         deb_cnt_d = 4'd0;
         armed_d   = 1'b1;
      end else if (deb_cnt_q != DEB_MAX) begin
         deb_cnt_d = deb_cnt_q + 4'd1;
         if ((deb_cnt_d == DEB_MAX) && armed_q) begin
            press_ev = 1'b1;
            armed_d  = 1'b0;
         end
      end
   end

   // A press landing on the same edge as a phase end or a fault still counts
   // as a queued request.
   assign pend_eff = pending_q | press_ev;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      timer_d   = timer_q;
      request_d = request_q;
      walk_d    = walk_q;
      dw_d      = dw_q;
      count_d   = count_q;
      done_d    = 1'b0;
      error_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (press_ev) begin
               state_d   = S_REQUEST;
               request_d = 1'b1;
            end
         end

         S_REQUEST: begin
            if (red) begin
               state_d   = S_WALK;
               request_d = 1'b0;
               walk_d    = 1'b1;
               dw_d      = 1'b0;
               count_d   = WALK_LOAD;
            end
         end

         S_WALK, S_FLASH: begin
            pending_d = pend_eff;
            if (!red) begin
               // Fault has priority over count expiry on the same edge.
               walk_d  = 1'b0;
               dw_d    = 1'b1;
               count_d = 4'd0;
               error_d = 1'b1;
               if (pend_eff) begin
                  state_d   = S_REQUEST;
                  request_d = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (state_q == S_WALK) begin
               if (count_q == 4'd0) begin
                  state_d = S_FLASH;
                  walk_d  = 1'b0;
                  dw_d    = 1'b1;
                  count_d = FLASH_LOAD;
                  timer_d = 3'd0;
               end else begin
                  count_d = count_q - 4'd1;
               end
            end else begin
               if (count_q == 4'd0) begin
                  done_d = 1'b1;
                  dw_d   = 1'b1;
                  if (pend_eff) begin
                     state_d   = S_REQUEST;
                     request_d = 1'b1;
                     pending_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  count_d = count_q - 4'd1;
                  // Toggle every FLASH_PERIOD edges, counted from FLASH entry.
                  if (timer_q == PER_LAST) begin
                     timer_d = 3'd0;
                     dw_d    = ~dw_q;
                  end else begin
                     timer_d = timer_q + 3'd1;
                  end
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         deb_cnt_q <= 4'd0;
         armed_q   <= 1'b1;
         pending_q <= 1'b0;
         timer_q   <= 3'd0;
         request_q <= 1'b0;
         walk_q    <= 1'b0;
         dw_q      <= 1'b1;
         count_q   <= 4'd0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
         armed_q   <= armed_d;
         pending_q <= pending_d;
         timer_q   <= timer_d;
         request_q <= request_d;
         walk_q    <= walk_d;
         dw_q      <= dw_d;
         count_q   <= count_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign request   = request_q;
   assign walk      = walk_q;
   assign dont_walk = dw_q;
   assign count     = count_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_ped_crossing_controller.sv
// Purpose : self-checking bench for ped_crossing_controller; directed scenarios
//           followed by randomized button/lights traffic against a phase/elapsed model.
// Timing  : inputs change 1 time unit after a rising edge; outputs checked 1 unit after.
module tb_ped_crossing_controller;

   localparam int DEB   = 4;
   localparam int WALKC = 8;
   localparam int FLSHC = 6;
   localparam int FPER  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       button_raw = 1'b0;
   logic [2:0] lights = 3'b001;
   logic       request, walk, dont_walk, done, error;
   logic [3:0] count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ped_crossing_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .WALK_CYCLES    (WALKC),
      .FLASH_CYCLES   (FLSHC),
      .FLASH_PERIOD   (FPER)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .button_raw(button_raw),
      .lights    (lights),
      .request   (request),
      .walk      (walk),
      .dont_walk (dont_walk),
      .count     (count),
      .done      (done),
      .error     (error)
   );

   // Reference model: phase name + cycles elapsed in that phase, and the length
   // of the current run of high button samples.
   string m_phase = "idle";
   int    m_el    = 0;
   int    m_run   = 0;
   bit    m_pend  = 0;
   bit    e_req, e_walk, e_dw, e_done, e_err;
   int    e_cnt;

   task automatic model_step(input bit b, input bit [2:0] l, input bit rst);
      bit press;
      if (rst) begin
         m_phase = "idle"; m_el = 0; m_run = 0; m_pend = 0;
         e_done = 0; e_err = 0;
      end else begin
         m_run  = b ? m_run + 1 : 0;
         press  = (m_run == DEB);
         e_done = 0;
         e_err  = 0;
         if (m_phase == "idle") begin
            if (press) m_phase = "request";
         end else if (m_phase == "request") begin
            if (l == 3'b100) begin m_phase = "walk"; m_el = 0; end
         end else begin
            if (press) m_pend = 1;
            if (l != 3'b100) begin
               e_err   = 1;
               m_phase = m_pend ? "request" : "idle";
               m_pend  = 0;
            end else if (m_phase == "walk") begin
               m_el++;
               if (m_el == WALKC) begin m_phase = "flash"; m_el = 0; end
            end else begin
               m_el++;
               if (m_el == FLSHC) begin
                  e_done  = 1;
                  m_phase = m_pend ? "request" : "idle";
                  m_pend  = 0;
               end
            end
         end
      end
      e_req  = (m_phase == "request");
      e_walk = (m_phase == "walk");
      if (m_phase == "walk")       e_cnt = WALKC - 1 - m_el;
      else if (m_phase == "flash") e_cnt = FLSHC - 1 - m_el;
      else                         e_cnt = 0;
      if (m_phase == "walk")       e_dw = 0;
      else if (m_phase == "flash") e_dw = ((m_el / FPER) % 2) == 0;
      else                         e_dw = 1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("request",   int'(request),   int'(e_req));
      chk("walk",      int'(walk),      int'(e_walk));
      chk("dont_walk", int'(dont_walk), int'(e_dw));
      chk("count",     int'(count),     e_cnt);
      chk("done",      int'(done),      int'(e_done));
      chk("error",     int'(error),     int'(e_err));
   endtask

   // One clock cycle with the given inputs, model update, then output check.
   task automatic cyc(input bit b, input bit [2:0] l, input bit rst);
      button_raw = b;
      lights     = l;
      reset      = rst;
      @(posedge clk);
      model_step(b, l, rst);
      #1;
      chk_all();
   endtask

   task automatic press_btn(input bit [2:0] l);
      for (int i = 0; i < DEB; i++) cyc(1'b1, l, 1'b0);
      cyc(1'b0, l, 1'b0);
   endtask

   initial begin
      int  n;
      int  dones;
      bit  b_r;
      bit  [2:0] l_r;

      #1;
      // 1. reset and idle
      cyc(0, 3'b001, 1);
      cyc(0, 3'b001, 1);
      chk("rst_dont_walk", int'(dont_walk), 1);
      for (int i = 0; i < 4; i++) cyc(0, 3'b001, 0);

      // 2. short bursts do not count; a full press does, once
      for (int i = 0; i < 3; i++) cyc(1, 3'b001, 0);
      cyc(0, 3'b001, 0);
      for (int i = 0; i < 3; i++) cyc(1, 3'b001, 0);
      cyc(0, 3'b001, 0);
      chk("no_req_short", int'(request), 0);
      for (int i = 0; i < DEB; i++) cyc(1, 3'b001, 0);
      chk("req_on_4th", int'(request), 1);
      for (int i = 0; i < 20; i++) cyc(1, 3'b001, 0);
      cyc(0, 3'b001, 0);

      // 3. full crossing
      for (int i = 0; i < 10; i++) cyc(0, 3'b001, 0);
      chk("req_held", int'(request), 1);
      cyc(0, 3'b100, 0);
      chk("walk_entry_cnt", int'(count), WALKC - 1);
      chk("walk_entry_req", int'(request), 0);
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(0, 3'b100, 0);
         if (done) dones++;
      end
      chk("done_once", dones, 1);
      cyc(0, 3'b100, 0);
      chk("idle_after", int'(dont_walk), 1);

      // 4. lights leave red during WALK at count 4
      press_btn(3'b001);
      cyc(0, 3'b100, 0);
      for (int i = 0; i < 3; i++) cyc(0, 3'b100, 0);
      chk("walk_cnt4", int'(count), 4);
      cyc(0, 3'b010, 0);
      chk("viol_error", int'(error), 1);
      chk("viol_count", int'(count), 0);
      cyc(0, 3'b010, 0);
      chk("error_pulse", int'(error), 0);

      // 5. press during WALK queues the next crossing
      press_btn(3'b001);
      cyc(0, 3'b100, 0);
      press_btn(3'b100);
      n = 0;
      while (!e_done && n < 40) begin cyc(0, 3'b100, 0); n++; end
      chk("pend_reach_done", int'(n < 40), 1);
      chk("pend_done", int'(done), 1);
      chk("pend_request", int'(request), 1);
      cyc(0, 3'b100, 0);
      chk("rewalk", int'(walk), 1);
      chk("rewalk_cnt", int'(count), WALKC - 1);

      // 6. reset mid-FLASH with a pending press
      press_btn(3'b100);
      n = 0;
      while (!(m_phase == "flash" && e_cnt == 3) && n < 40) begin cyc(0, 3'b100, 0); n++; end
      chk("reach_flash3", int'(n < 40), 1);
      cyc(0, 3'b100, 1);
      chk("rst_walk", int'(walk), 0);
      for (int i = 0; i < 10; i++) cyc(0, 3'b100, 0);
      chk("no_req_after_rst", int'(request), 0);

      // Randomized traffic: sticky button, mostly-red lights, rare resets.
      b_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 15) b_r = ~b_r;
         if ($urandom_range(0, 99) < 85) l_r = 3'b100;
         else l_r = 3'($urandom_range(0, 7));
         cyc(b_r, l_r, ($urandom_range(0, 999) < 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
